// File: rtl/cellrv32_fifo_lvl.sv
// cellrv32_fifo_lvl: single-clock FIFO with exact fill level, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags
//   clk_i/rstn_i             clock, async active-low reset
//   clear_i                  synchronous flush of both pointers
//   wdata_i/we_i/free_o      write side
//   rdata_o/re_i/avail_o     read side
//   level_o/half_o           fill level and half-full status
//   afull_thr_i/afull_o      almost-full threshold and flag (level >= thr)
//   aempty_thr_i/aempty_o    almost-empty threshold and flag (level <= thr)
//   err_clr_i/ovf_o/unf_o    sticky error flags and their clear
module cellrv32_fifo_lvl #(
  parameter int   FIFO_DEPTH = 4,
  parameter int   FIFO_WIDTH = 8,
  parameter logic FIFO_RSYNC = 1'b0,
  parameter logic FIFO_SAFE  = 1'b0,
  parameter logic FIFO_GATE  = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          clear_i,
  input  logic [FIFO_WIDTH-1:0]         wdata_i,
  input  logic                          we_i,
  output logic                          free_o,
  input  logic                          re_i,
  output logic [FIFO_WIDTH-1:0]         rdata_o,
  output logic                          avail_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          half_o,
  input  logic [$clog2(FIFO_DEPTH):0]   afull_thr_i,
  input  logic [$clog2(FIFO_DEPTH):0]   aempty_thr_i,
  output logic                          afull_o,
  output logic                          aempty_o,
  input  logic                          err_clr_i,
  output logic                          ovf_o,
  output logic                          unf_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  if ((FIFO_DEPTH < 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_WIDTH < 1))
    $error("CELLRV32 CONFIG ERROR: FIFO_DEPTH must be a power of two >= 1 and FIFO_WIDTH >= 1");
  logic [LW-1:0]         w_pnt, r_pnt;
  logic                  full, we, re;
  logic [FIFO_WIDTH-1:0] mem_rd, rdata_q, rdata;
  assign level_o  = w_pnt - r_pnt;
  assign full     = level_o == LW'(FIFO_DEPTH);
  assign free_o   = ~full;
  assign avail_o  = |level_o;
  assign half_o   = (FIFO_DEPTH == 1) ? level_o[0] : (level_o >= LW'(FIFO_DEPTH / 2));
  assign afull_o  = level_o >= afull_thr_i;
  assign aempty_o = level_o <= aempty_thr_i;
  assign we       = we_i & (~FIFO_SAFE | free_o);
  assign re       = re_i & (~FIFO_SAFE | avail_o);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_pnt <= '0;
      r_pnt <= '0;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      w_pnt <= clear_i ? '0 : w_pnt + LW'(we);
      r_pnt <= clear_i ? '0 : r_pnt + LW'(re);
      // a new error in the same cycle as a clear keeps the flag set
      ovf_o <= (we_i & full) | (ovf_o & ~(err_clr_i | clear_i));
      unf_o <= (re_i & ~avail_o) | (unf_o & ~(err_clr_i | clear_i));
    end
  end
  if (FIFO_DEPTH == 1) begin : g_reg
    logic [FIFO_WIDTH-1:0] mem_q;
    always_ff @(posedge clk_i) if (we) mem_q <= wdata_i;
    assign mem_rd = mem_q;
  end else begin : g_mem
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    always_ff @(posedge clk_i) if (we) mem[w_pnt[LW-2:0]] <= wdata_i;
    assign mem_rd = mem[r_pnt[LW-2:0]];
  end
  always_ff @(posedge clk_i) rdata_q <= mem_rd;
  assign rdata   = FIFO_RSYNC ? rdata_q : mem_rd;
  assign rdata_o = (~FIFO_GATE | avail_o) ? rdata : '0;
endmodule

// File: tb/tb_cellrv32_fifo_lvl.sv
// tb_cellrv32_fifo_lvl: directed bench for the level/threshold/error FIFO
module tb_cellrv32_fifo_lvl;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  logic       clr = 0, we = 0, re = 0, ec = 0;
  logic [7:0] wd = 0;
  logic [2:0] at = 3'd4, et = 3'd0;
  logic       fr, av, hf, af, ae, ov, un;
  logic [7:0] rd;
  logic [2:0] lv;
  logic       clr1 = 0, we1 = 0, re1 = 0, ec1 = 0;
  logic [7:0] wd1 = 0;
  logic [2:0] at1 = 3'd4, et1 = 3'd0;
  logic       fr1, av1, hf1, af1, ae1, ov1, un1;
  logic [7:0] rd1;
  logic [2:0] lv1;
  cellrv32_fifo_lvl #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FIFO_RSYNC(1'b0), .FIFO_SAFE(1'b1), .FIFO_GATE(1'b1)) u0 (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clr), .wdata_i(wd), .we_i(we), .free_o(fr), .re_i(re), .rdata_o(rd),
    .avail_o(av), .level_o(lv), .half_o(hf), .afull_thr_i(at), .aempty_thr_i(et), .afull_o(af), .aempty_o(ae),
    .err_clr_i(ec), .ovf_o(ov), .unf_o(un));
  cellrv32_fifo_lvl #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FIFO_RSYNC(1'b1), .FIFO_SAFE(1'b1), .FIFO_GATE(1'b0)) u1 (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clr1), .wdata_i(wd1), .we_i(we1), .free_o(fr1), .re_i(re1), .rdata_o(rd1),
    .avail_o(av1), .level_o(lv1), .half_o(hf1), .afull_thr_i(at1), .aempty_thr_i(et1), .afull_o(af1), .aempty_o(ae1),
    .err_clr_i(ec1), .ovf_o(ov1), .unf_o(un1));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #12;
    n_cmp++; if (lv !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", lv); end
    n_cmp++; if (av !== 1'b0) begin n_err++; $display("FAIL reset_avail got %b exp 0", av); end
    n_cmp++; if (fr !== 1'b1) begin n_err++; $display("FAIL reset_free got %b exp 1", fr); end
    n_cmp++; if (hf !== 1'b0) begin n_err++; $display("FAIL reset_half got %b exp 0", hf); end
    n_cmp++; if (ae !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b exp 1", ae); end
    n_cmp++; if (af !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b exp 0", af); end
    n_cmp++; if ({ov, un} !== 2'b00) begin n_err++; $display("FAIL reset_err got %b exp 00", {ov, un}); end
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL reset_rdata_gated got %h exp 00", rd); end
    at = 3'd0;
    #1;
    n_cmp++; if (af !== 1'b1) begin n_err++; $display("FAIL reset_afull_thr0 got %b exp 1", af); end
    at = 3'd4;
    rstn = 1'b1;
    tick();
  endtask
  task automatic test_fill;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      we = 1; wd = vals[i];
      tick();
      n_cmp++; if (lv !== 3'(i + 1)) begin n_err++; $display("FAIL fill_level got %0d exp %0d", lv, i + 1); end
      n_cmp++; if (hf !== (i >= 1)) begin n_err++; $display("FAIL fill_half got %b exp %b", hf, i >= 1); end
      n_cmp++; if (fr !== (i < 3)) begin n_err++; $display("FAIL fill_free got %b exp %b", fr, i < 3); end
    end
    we = 0;
    n_cmp++; if (rd !== 8'h11) begin n_err++; $display("FAIL fill_rdata got %h exp 11", rd); end
  endtask
  task automatic test_full_rw;
    logic [7:0] vals [3] = '{8'h22, 8'h33, 8'h44};
    we = 1; wd = 8'h55; re = 1;
    #1;
    n_cmp++; if (rd !== 8'h11) begin n_err++; $display("FAIL fullrw_rdata got %h exp 11", rd); end
    tick();
    we = 0; re = 0;
    n_cmp++; if (ov !== 1'b1) begin n_err++; $display("FAIL fullrw_ovf got %b exp 1", ov); end
    n_cmp++; if (lv !== 3'd3) begin n_err++; $display("FAIL fullrw_level got %0d exp 3", lv); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rd !== vals[i]) begin n_err++; $display("FAIL fullrw_read got %h exp %h", rd, vals[i]); end
      re = 1;
      tick();
      re = 0;
    end
    n_cmp++; if (lv !== 3'd0) begin n_err++; $display("FAIL fullrw_drained got %0d exp 0", lv); end
    n_cmp++; if (ov !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", ov); end
    ec = 1;
    tick();
    ec = 0;
    n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", ov); end
  endtask
  task automatic test_underflow;
    re = 1;
    tick();
    re = 0;
    n_cmp++; if (lv !== 3'd0) begin n_err++; $display("FAIL unf_level got %0d exp 0", lv); end
    n_cmp++; if (un !== 1'b1) begin n_err++; $display("FAIL unf_flag got %b exp 1", un); end
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL unf_rdata_gated got %h exp 00", rd); end
    ec = 1;
    tick();
    ec = 0;
    n_cmp++; if (un !== 1'b0) begin n_err++; $display("FAIL unf_clear got %b exp 0", un); end
    re = 1; ec = 1;
    tick();
    re = 0; ec = 0;
    n_cmp++; if (un !== 1'b1) begin n_err++; $display("FAIL unf_set_wins got %b exp 1", un); end
    ec = 1;
    tick();
    ec = 0;
  endtask
  task automatic test_thresholds;
    logic [1:0] up [5] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    at = 3'd3; et = 3'd1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin we = 1; wd = 8'(8'h60 + i); tick(); we = 0; end
      n_cmp++; if ({af, ae} !== up[i]) begin n_err++; $display("FAIL thr_fill lvl %0d got %b exp %b", i, {af, ae}, up[i]); end
    end
    at = 3'd5;
    #1;
    n_cmp++; if (af !== 1'b0) begin n_err++; $display("FAIL thr_above_depth got %b exp 0", af); end
    at = 3'd3;
    for (int i = 3; i >= 0; i--) begin
      re = 1; tick(); re = 0;
      n_cmp++; if ({af, ae} !== up[i]) begin n_err++; $display("FAIL thr_drain lvl %0d got %b exp %b", i, {af, ae}, up[i]); end
    end
    we = 1; wd = 8'h80;
    tick();
    for (int i = 0; i < 8; i++) begin
      re = 1; wd = 8'(8'h81 + i);
      #1;
      n_cmp++; if (rd !== 8'(8'h80 + i)) begin n_err++; $display("FAIL wrap_data got %h exp %h", rd, 8'(8'h80 + i)); end
      tick();
      n_cmp++; if (lv !== 3'd1) begin n_err++; $display("FAIL wrap_level got %0d exp 1", lv); end
    end
    we = 0;
    n_cmp++; if (rd !== 8'h88) begin n_err++; $display("FAIL wrap_last got %h exp 88", rd); end
    tick();
    re = 0;
    n_cmp++; if (lv !== 3'd0) begin n_err++; $display("FAIL wrap_empty got %0d exp 0", lv); end
  endtask
  task automatic test_rsync;
    we1 = 1; wd1 = 8'hA5;
    tick();
    we1 = 0;
    n_cmp++; if (av1 !== 1'b1) begin n_err++; $display("FAIL rsync_avail got %b exp 1", av1); end
    tick();
    n_cmp++; if (rd1 !== 8'hA5) begin n_err++; $display("FAIL rsync_rdata got %h exp a5", rd1); end
    for (int k = 0; k < 4; k++) begin
      we1 = 1; re1 = 1; wd1 = 8'(8'hB0 + k);
      tick();
      n_cmp++; if (lv1 !== 3'd1) begin n_err++; $display("FAIL rsync_level got %0d exp 1", lv1); end
      n_cmp++; if (rd1 !== ((k == 0) ? 8'hA5 : 8'(8'hB0 + k - 1))) begin n_err++; $display("FAIL rsync_stream got %h exp %h", rd1, (k == 0) ? 8'hA5 : 8'(8'hB0 + k - 1)); end
    end
    we1 = 0; re1 = 0;
    tick();
    n_cmp++; if (rd1 !== 8'hB3) begin n_err++; $display("FAIL rsync_tail got %h exp b3", rd1); end
  endtask
  task automatic test_clear_reset;
    we = 1; wd = 8'h01; tick(); wd = 8'h02; tick();
    n_cmp++; if (lv !== 3'd2) begin n_err++; $display("FAIL clr_pre_level got %0d exp 2", lv); end
    clr = 1; wd = 8'h03;
    tick();
    clr = 0;
    n_cmp++; if (lv !== 3'd0) begin n_err++; $display("FAIL clr_level got %0d exp 0", lv); end
    n_cmp++; if (av !== 1'b0) begin n_err++; $display("FAIL clr_avail got %b exp 0", av); end
    tick(); tick(); tick();
    we = 0;
    n_cmp++; if (lv !== 3'd3) begin n_err++; $display("FAIL rst_pre_level got %0d exp 3", lv); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (lv !== 3'd0) begin n_err++; $display("FAIL arst_level got %0d exp 0", lv); end
    n_cmp++; if ({av, fr, hf} !== 3'b010) begin n_err++; $display("FAIL arst_status got %b exp 010", {av, fr, hf}); end
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL arst_rdata got %h exp 00", rd); end
    #1 rstn = 1'b1;
  endtask
  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_underflow();
    test_thresholds();
    test_rsync();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
